// File: rtl/wf_done_handshake_ctrl_pkg.sv
// wf_done_handshake_ctrl_pkg: shared sizes, FSM encoding and the enabled id decoder
package wf_done_handshake_ctrl_pkg;
  localparam int WF_PER_CU = 40;
  localparam int WF_ID_LENGTH = 6;
  localparam int TIMEOUT_W = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, CLEAR = 2'd2} state_t;
  function automatic logic [WF_PER_CU-1:0] dec_en(input logic en, input logic [WF_ID_LENGTH-1:0] id);
    dec_en = '0;
    if (en && int'(id) < WF_PER_CU) dec_en[id] = 1'b1;
  endfunction
endpackage

// File: rtl/wf_done_handshake_ctrl_if.sv
// wf_done_handshake_ctrl_if: done-request, flush and dispatcher handshake bundle
interface wf_done_handshake_ctrl_if import wf_done_handshake_ctrl_pkg::*; ();
  logic [WF_PER_CU-1:0] done_req_array;
  logic flush_wf_en;
  logic [WF_ID_LENGTH-1:0] flush_wf_id;
  logic wf_done_ack;
  logic wf_done_valid;
  logic [WF_ID_LENGTH-1:0] wf_done_wf_id;
  logic done_clear_en;
  logic [WF_ID_LENGTH-1:0] done_clear_wf_id;
  logic ack_timeout;
  modport slave (
    input done_req_array, flush_wf_en, flush_wf_id, wf_done_ack,
    output wf_done_valid, wf_done_wf_id, done_clear_en, done_clear_wf_id, ack_timeout
  );
  modport master (
    output done_req_array, flush_wf_en, flush_wf_id, wf_done_ack,
    input wf_done_valid, wf_done_wf_id, done_clear_en, done_clear_wf_id, ack_timeout
  );
endinterface

// File: rtl/wf_done_handshake_ctrl_rr_select_wf.sv
// rr_select_wf: round-robin pick of the first eligible wavefront after rr_ptr
module rr_select_wf import wf_done_handshake_ctrl_pkg::*; (
  input  logic [WF_PER_CU-1:0]    eligible_i,
  input  logic [WF_ID_LENGTH-1:0] rr_ptr_i,
  output logic [WF_ID_LENGTH-1:0] win_id_o,
  output logic                    found_o
);
  int idx;
  // scan farthest offset first so the nearest slot after rr_ptr overwrites and wins
  always_comb begin
    win_id_o = '0;
    found_o = 1'b0;
    idx = 0;
    for (int k = WF_PER_CU; k >= 1; k--) begin
      idx = int'(rr_ptr_i) + k;
      idx = (idx >= WF_PER_CU) ? idx - WF_PER_CU : idx;
      if (eligible_i[idx]) begin
        found_o = 1'b1;
        win_id_o = WF_ID_LENGTH'(idx);
      end
    end
  end
endmodule

// File: rtl/wf_done_handshake_ctrl.sv
// wf_done_handshake_ctrl: round-robin completion reporting with ack handshake and clear pulse
module wf_done_handshake_ctrl import wf_done_handshake_ctrl_pkg::*; (
  input logic clk,
  input logic rst,
  wf_done_handshake_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [WF_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, clr_id_q, clr_id_d, win_id;
  logic [WF_PER_CU-1:0] issued_q, issued_d, eligible;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic valid_q, valid_d, clr_en_q, clr_en_d, tmo_q, tmo_d, found, ack_hit;
  assign eligible = bus.done_req_array & ~issued_q & ~dec_en(bus.flush_wf_en, bus.flush_wf_id);
  assign ack_hit = (state_q == PRESENT) && bus.wf_done_ack;
  rr_select_wf u_sel (
    .eligible_i(eligible),
    .rr_ptr_i  (rr_ptr_q),
    .win_id_o  (win_id),
    .found_o   (found)
  );
  // handshake FSM plus mask and watchdog next state; acked ids stay masked until their request drops
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    valid_d = valid_q;
    clr_en_d = clr_en_q;
    clr_id_d = clr_id_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = PRESENT;
        valid_d = 1'b1;
        id_d = win_id;
        rr_ptr_d = win_id;
      end
      PRESENT: if (bus.wf_done_ack) begin
        state_d = CLEAR;
        valid_d = 1'b0;
        clr_en_d = 1'b1;
        clr_id_d = id_q;
      end else if (bus.flush_wf_en && bus.flush_wf_id == id_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      CLEAR: begin
        state_d = IDLE;
        clr_en_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    issued_d = (issued_q & bus.done_req_array) | dec_en(ack_hit, id_q);
    wd_d = (state_q == PRESENT && state_d == PRESENT) ? (&wd_q ? wd_q : wd_q + 1'b1) : '0;
    tmo_d = tmo_q | (&wd_d);
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= WF_ID_LENGTH'(WF_PER_CU - 1);
      id_q <= '0;
      valid_q <= 1'b0;
      clr_en_q <= 1'b0;
      clr_id_q <= '0;
      issued_q <= '0;
      wd_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      valid_q <= valid_d;
      clr_en_q <= clr_en_d;
      clr_id_q <= clr_id_d;
      issued_q <= issued_d;
      wd_q <= wd_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.wf_done_valid = valid_q;
  assign bus.wf_done_wf_id = id_q;
  assign bus.done_clear_en = clr_en_q;
  assign bus.done_clear_wf_id = clr_id_q;
  assign bus.ack_timeout = tmo_q;
endmodule

// File: tb/tb_wf_done_handshake_ctrl.sv
// tb_wf_done_handshake_ctrl: directed checks of selection order, flush, ack/clear, watchdog and reset
module tb_wf_done_handshake_ctrl;
  import wf_done_handshake_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  wf_done_handshake_ctrl_if bus ();
  wf_done_handshake_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_valid"}, 64'(bus.wf_done_valid), 0);
    chk({tag, "_id"}, 64'(bus.wf_done_wf_id), 0);
    chk({tag, "_clr"}, 64'(bus.done_clear_en), 0);
    chk({tag, "_clr_id"}, 64'(bus.done_clear_wf_id), 0);
    chk({tag, "_tmo"}, 64'(bus.ack_timeout), 0);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask
  task automatic get_report(input int exp_id, input string tag);
    for (int i = 0; i < 8 && !bus.wf_done_valid; i++) step();
    chk({tag, "_valid"}, 64'(bus.wf_done_valid), 1);
    chk({tag, "_id"}, 64'(bus.wf_done_wf_id), 64'(exp_id));
    bus.wf_done_ack = 1'b1;
    step();
    bus.wf_done_ack = 1'b0;
    chk({tag, "_clr"}, 64'(bus.done_clear_en), 1);
    chk({tag, "_clr_id"}, 64'(bus.done_clear_wf_id), 64'(exp_id));
    chk({tag, "_drop"}, 64'(bus.wf_done_valid), 0);
    step();
    chk({tag, "_clr_pulse"}, 64'(bus.done_clear_en), 0);
  endtask
  initial begin
    bus.done_req_array = '0;
    bus.flush_wf_en = 1'b0;
    bus.flush_wf_id = '0;
    bus.wf_done_ack = 1'b0;
    do_reset("rst0");
    bus.done_req_array[5] = 1'b1;
    step();
    chk("t1_valid", 64'(bus.wf_done_valid), 1);
    chk("t1_id", 64'(bus.wf_done_wf_id), 5);
    step();
    chk("t1_hold", 64'(bus.wf_done_valid), 1);
    bus.wf_done_ack = 1'b1;
    step();
    bus.wf_done_ack = 1'b0;
    chk("t1_clr", 64'(bus.done_clear_en), 1);
    chk("t1_clr_id", 64'(bus.done_clear_wf_id), 5);
    chk("t1_drop", 64'(bus.wf_done_valid), 0);
    step();
    chk("t1_clr_pulse", 64'(bus.done_clear_en), 0);
    repeat (6) step();
    chk("t1_masked", 64'(bus.wf_done_valid), 0);
    bus.done_req_array = '0;
    bus.done_req_array[3] = 1'b1;
    bus.done_req_array[7] = 1'b1;
    bus.done_req_array[39] = 1'b1;
    do_reset("rst1");
    get_report(3, "t2a_3");
    get_report(7, "t2a_7");
    get_report(39, "t2a_39");
    repeat (3) step();
    chk("t2_all_masked", 64'(bus.wf_done_valid), 0);
    bus.done_req_array = '0;
    step();
    step();
    bus.done_req_array[3] = 1'b1;
    bus.done_req_array[7] = 1'b1;
    bus.done_req_array[39] = 1'b1;
    get_report(3, "t2b_3");
    get_report(7, "t2b_7");
    get_report(39, "t2b_39");
    bus.done_req_array = '0;
    step();
    bus.done_req_array[12] = 1'b1;
    step();
    chk("t3_valid", 64'(bus.wf_done_valid), 1);
    chk("t3_id", 64'(bus.wf_done_wf_id), 12);
    bus.flush_wf_en = 1'b1;
    bus.flush_wf_id = 6'd12;
    step();
    chk("t3_flush_drop", 64'(bus.wf_done_valid), 0);
    chk("t3_flush_noclr", 64'(bus.done_clear_en), 0);
    step();
    chk("t3_flush_gated", 64'(bus.wf_done_valid), 0);
    bus.flush_wf_en = 1'b0;
    step();
    chk("t3_rereport", 64'(bus.wf_done_valid), 1);
    chk("t3_rereport_id", 64'(bus.wf_done_wf_id), 12);
    bus.flush_wf_en = 1'b1;
    bus.flush_wf_id = 6'd13;
    step();
    chk("t3_other_flush", 64'(bus.wf_done_valid), 1);
    chk("t3_other_flush_id", 64'(bus.wf_done_wf_id), 12);
    bus.flush_wf_id = 6'd12;
    bus.wf_done_ack = 1'b1;
    step();
    bus.wf_done_ack = 1'b0;
    bus.flush_wf_en = 1'b0;
    chk("t4_clr", 64'(bus.done_clear_en), 1);
    chk("t4_clr_id", 64'(bus.done_clear_wf_id), 12);
    chk("t4_drop", 64'(bus.wf_done_valid), 0);
    step();
    chk("t4_clr_pulse", 64'(bus.done_clear_en), 0);
    repeat (4) step();
    chk("t4_masked", 64'(bus.wf_done_valid), 0);
    bus.done_req_array = '0;
    bus.done_req_array[30] = 1'b1;
    step();
    chk("t5_valid", 64'(bus.wf_done_valid), 1);
    chk("t5_id", 64'(bus.wf_done_wf_id), 30);
    repeat (1022) step();
    chk("t5_tmo_before", 64'(bus.ack_timeout), 0);
    step();
    chk("t5_tmo_set", 64'(bus.ack_timeout), 1);
    chk("t5_still_valid", 64'(bus.wf_done_valid), 1);
    bus.wf_done_ack = 1'b1;
    step();
    bus.wf_done_ack = 1'b0;
    chk("t5_clr_id", 64'(bus.done_clear_wf_id), 30);
    step();
    step();
    chk("t5_tmo_sticky", 64'(bus.ack_timeout), 1);
    bus.done_req_array = '0;
    bus.done_req_array[20] = 1'b1;
    step();
    chk("t6_valid", 64'(bus.wf_done_valid), 1);
    chk("t6_id", 64'(bus.wf_done_wf_id), 20);
    do_reset("t6_rst");
    step();
    chk("t6_rereport", 64'(bus.wf_done_valid), 1);
    chk("t6_rereport_id", 64'(bus.wf_done_wf_id), 20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
